// File: rtl/audio_stream_buffer_if.sv
// Purpose : bundles the sample-in, key-in and codec-out signals of the audio buffer.
// Latency : none, wiring only.
// Backpressure: audio_ready from the codec stalls confirm_pass/pass_data_audio.
// Ports   : synced_sig/getdata (sample strobe), key_control/key_valid (scancodes),
//           audio_ready/pass_data_audio/confirm_pass (codec handshake),
//           playing/muted/drop_count (status).
interface audio_stream_buffer_if #(
  parameter int DATA_W = 16
);
  logic              synced_sig;
  logic [DATA_W-1:0] getdata;
  logic [7:0]        key_control;
  logic              key_valid;
  logic              audio_ready;
  logic [DATA_W-1:0] pass_data_audio;
  logic              confirm_pass;
  logic              playing;
  logic              muted;
  logic [7:0]        drop_count;

  // Source side: audio source, keyboard and codec as seen from outside the buffer.
  modport master (
    output synced_sig, getdata, key_control, key_valid, audio_ready,
    input  pass_data_audio, confirm_pass, playing, muted, drop_count
  );

  // Buffer side.
  modport slave (
    input  synced_sig, getdata, key_control, key_valid, audio_ready,
    output pass_data_audio, confirm_pass, playing, muted, drop_count
  );
endinterface

// File: rtl/audio_stream_buffer.sv
// Purpose : keyboard-controlled play/stop/mute buffer between audio source and codec.
// Latency : 2 cycles strobe-to-valid (FIFO write, then output register load).
// Backpressure: audio_ready low holds the output word; FIFO fills, then samples drop and are counted.
// Ports   : clock50, rstn (async active-low); bus (slave modport) carries sample input,
//           scancode input, codec valid/ready output and playing/muted/drop_count status.
module audio_stream_buffer #(
  parameter int          DATA_W    = 16,
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  KEY_STOP  = 8'h23,
  parameter logic [7:0]  KEY_START = 8'h24,
  parameter logic [7:0]  KEY_MUTE  = 8'h3A
) (
  input  logic                  clock50,
  input  logic                  rstn,
  audio_stream_buffer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {STOPPED = 1'b0, PLAYING = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] out_data;
  logic              out_vld;
  logic              muted_q;
  logic [7:0]        drop_q;

  logic key_stop, key_start, key_mute;
  logic empty, full, pop, accept, push, drop;

  assign key_stop  = bus.key_valid && (bus.key_control == KEY_STOP);
  assign key_start = bus.key_valid && (bus.key_control == KEY_START);
  assign key_mute  = bus.key_valid && (bus.key_control == KEY_MUTE);

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A stop flushes the FIFO, so nothing is popped from it on that edge; the word
  // already held in the output register is unaffected and finishes its handshake.
  assign pop    = !empty && !key_stop && (!out_vld || bus.audio_ready);

  // Sample sees the pre-key state, except a same-cycle stop discards it uncounted.
  assign accept = bus.synced_sig && (state == PLAYING) && !key_stop;
  assign push   = accept && (!full || pop);
  assign drop   = accept && !push;

  // State register.
  always_ff @(posedge clock50 or negedge rstn) begin
    if (!rstn) begin
      state <= STOPPED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    if (key_stop) begin
      state_nxt = STOPPED;
    end else if (key_start && (state == STOPPED)) begin
      state_nxt = PLAYING;
    end
  end

  // FIFO pointers; cleared together on a stop.
  always_ff @(posedge clock50 or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (key_stop) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clock50) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.getdata;
    end
  end

  // Output register. Mute is applied at load time so a presented word never changes,
  // and a muted word still consumes its slot to keep the codec cadence.
  always_ff @(posedge clock50 or negedge rstn) begin
    if (!rstn) begin
      out_data <= '0;
      out_vld  <= 1'b0;
    end else if (pop) begin
      out_data <= muted_q ? '0 : mem[rd_ptr[AW-1:0]];
      out_vld  <= 1'b1;
    end else if (bus.audio_ready) begin
      out_vld  <= 1'b0;
    end
  end

  // Mute flag toggles on each mute scancode, in either state.
  always_ff @(posedge clock50 or negedge rstn) begin
    if (!rstn) begin
      muted_q <= 1'b0;
    end else if (key_mute) begin
      muted_q <= ~muted_q;
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clock50 or negedge rstn) begin
    if (!rstn) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.pass_data_audio = out_data;
  assign bus.confirm_pass    = out_vld;
  assign bus.playing         = (state == PLAYING);
  assign bus.muted           = muted_q;
  assign bus.drop_count      = drop_q;

endmodule

// File: tb/tb_audio_stream_buffer.sv
// Purpose : self-checking bench for audio_stream_buffer with a word scoreboard.
// Latency : checks the 2-cycle strobe-to-valid path and back-to-back output.
// Backpressure: exercises stalls, full-FIFO drops, saturation and flush.
module tb_audio_stream_buffer;

  localparam int         DATA_W = 16;
  localparam logic [7:0] K_STOP  = 8'h23;
  localparam logic [7:0] K_START = 8'h24;
  localparam logic [7:0] K_MUTE  = 8'h3A;

  logic clock50 = 1'b0;
  logic rstn;
  always #5 clock50 = ~clock50;

  audio_stream_buffer_if #(.DATA_W(DATA_W)) bus ();

  audio_stream_buffer #(
    .DATA_W(DATA_W), .DEPTH(4),
    .KEY_STOP(K_STOP), .KEY_START(K_START), .KEY_MUTE(K_MUTE)
  ) dut (
    .clock50 (clock50),
    .rstn    (rstn),
    .bus     (bus)
  );

  int                n_assert = 0;
  int                n_fail   = 0;
  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] exp_w;

  // Scoreboard consumer: a handshake visible between edges completes at the next edge.
  always @(negedge clock50) begin
    if (rstn === 1'b1 && bus.confirm_pass === 1'b1 && bus.audio_ready === 1'b1) begin
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL handshake_unexpected: got word %h, expected no word", bus.pass_data_audio);
      end else begin
        exp_w = sb.pop_front();
        if (bus.pass_data_audio !== exp_w) begin
          n_fail++;
          $display("FAIL handshake_data: got %h, expected %h", bus.pass_data_audio, exp_w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock50);
    #1;
  endtask

  task automatic send_key(input logic [7:0] k);
    bus.key_control = k;
    bus.key_valid   = 1'b1;
    tick();
    bus.key_valid   = 1'b0;
  endtask

  task automatic strobe(input logic [DATA_W-1:0] d, input bit expect_out, input logic [DATA_W-1:0] e);
    bus.synced_sig = 1'b1;
    bus.getdata    = d;
    if (expect_out) sb.push_back(e);
    tick();
    bus.synced_sig = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.synced_sig = 1'b0; bus.getdata = '0; bus.key_control = '0;
    bus.key_valid = 1'b0; bus.audio_ready = 1'b0;
    repeat (3) tick();
    n_assert++;
    if (bus.confirm_pass !== 1'b0 || bus.pass_data_audio !== '0) begin
      n_fail++; $display("FAIL reset_out: cp=%b data=%h, expected 0/0000", bus.confirm_pass, bus.pass_data_audio);
    end
    n_assert++;
    if (bus.playing !== 1'b0 || bus.muted !== 1'b0 || bus.drop_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_status: playing=%b muted=%b drops=%0d, expected 0/0/0", bus.playing, bus.muted, bus.drop_count);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    bus.audio_ready = 1'b1;
    send_key(K_START);
    n_assert++;
    if (bus.playing !== 1'b1) begin n_fail++; $display("FAIL start_playing: got %b, expected 1", bus.playing); end
    strobe(16'h1234, 1'b1, 16'h1234);
    n_assert++;
    if (bus.confirm_pass !== 1'b0) begin n_fail++; $display("FAIL latency_early: cp=%b, expected 0", bus.confirm_pass); end
    tick();
    n_assert++;
    if (bus.confirm_pass !== 1'b1 || bus.pass_data_audio !== 16'h1234) begin
      n_fail++; $display("FAIL latency_valid: cp=%b data=%h, expected 1/1234", bus.confirm_pass, bus.pass_data_audio);
    end
    tick();
    n_assert++;
    if (bus.confirm_pass !== 1'b0) begin n_fail++; $display("FAIL latency_one_cycle: cp=%b, expected 0", bus.confirm_pass); end
    n_assert++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL latency_drain: %0d words left, expected 0", sb.size()); end
  endtask

  task automatic test_stopped();
    send_key(K_STOP);
    n_assert++;
    if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL stop_playing: got %b, expected 0", bus.playing); end
    for (int i = 0; i < 3; i++) strobe(16'h0F00 + 16'(i), 1'b0, '0);
    repeat (2) tick();
    n_assert++;
    if (bus.confirm_pass !== 1'b0 || bus.drop_count !== 8'd0) begin
      n_fail++; $display("FAIL stopped_ignore: cp=%b drops=%0d, expected 0/0", bus.confirm_pass, bus.drop_count);
    end
    send_key(K_START);
    strobe(16'h55AA, 1'b1, 16'h55AA);
    repeat (3) tick();
    n_assert++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL restart_pass: %0d words left, expected 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] seq [4];
    seq = '{16'd3, 16'd4, 16'd5, 16'd7};
    bus.audio_ready = 1'b0;
    for (int i = 1; i <= 6; i++) strobe(16'(i), (i <= 5), 16'(i));
    n_assert++;
    if (bus.confirm_pass !== 1'b1 || bus.pass_data_audio !== 16'd1 || bus.drop_count !== 8'd1) begin
      n_fail++; $display("FAIL full_drop: cp=%b data=%h drops=%0d, expected 1/0001/1", bus.confirm_pass, bus.pass_data_audio, bus.drop_count);
    end
    // Raise ready together with a new sample: full FIFO pops and writes at once.
    bus.audio_ready = 1'b1;
    strobe(16'd7, 1'b1, 16'd7);
    n_assert++;
    if (bus.pass_data_audio !== 16'd2 || bus.drop_count !== 8'd1) begin
      n_fail++; $display("FAIL full_pop_write: data=%h drops=%0d, expected 0002/1", bus.pass_data_audio, bus.drop_count);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_assert++;
      if (bus.confirm_pass !== 1'b1 || bus.pass_data_audio !== seq[k]) begin
        n_fail++; $display("FAIL back_to_back[%0d]: cp=%b data=%h, expected 1/%h", k, bus.confirm_pass, bus.pass_data_audio, seq[k]);
      end
    end
    tick();
    n_assert++;
    if (bus.confirm_pass !== 1'b0 || sb.size() != 0) begin
      n_fail++; $display("FAIL drain_end: cp=%b left=%0d, expected 0/0", bus.confirm_pass, sb.size());
    end
  endtask

  task automatic test_mute();
    send_key(K_MUTE);
    n_assert++;
    if (bus.muted !== 1'b1) begin n_fail++; $display("FAIL mute_on: got %b, expected 1", bus.muted); end
    strobe(16'hABCD, 1'b1, 16'h0000);
    tick();
    n_assert++;
    if (bus.confirm_pass !== 1'b1 || bus.pass_data_audio !== 16'h0000) begin
      n_fail++; $display("FAIL mute_word: cp=%b data=%h, expected 1/0000", bus.confirm_pass, bus.pass_data_audio);
    end
    tick();
    send_key(K_MUTE);
    n_assert++;
    if (bus.muted !== 1'b0) begin n_fail++; $display("FAIL mute_off: got %b, expected 0", bus.muted); end
    strobe(16'h1357, 1'b1, 16'h1357);
    tick();
    n_assert++;
    if (bus.pass_data_audio !== 16'h1357) begin n_fail++; $display("FAIL unmute_word: data=%h, expected 1357", bus.pass_data_audio); end
    tick();
  endtask

  task automatic test_stop_flush();
    bus.audio_ready = 1'b0;
    strobe(16'hA001, 1'b1, 16'hA001);
    strobe(16'hA002, 1'b0, '0);
    strobe(16'hA003, 1'b0, '0);
    strobe(16'hA004, 1'b0, '0);
    tick();
    send_key(K_STOP);
    n_assert++;
    if (bus.playing !== 1'b0 || bus.confirm_pass !== 1'b1 || bus.pass_data_audio !== 16'hA001) begin
      n_fail++; $display("FAIL stop_hold: playing=%b cp=%b data=%h, expected 0/1/a001", bus.playing, bus.confirm_pass, bus.pass_data_audio);
    end
    bus.audio_ready = 1'b1;
    repeat (6) tick();
    n_assert++;
    if (bus.confirm_pass !== 1'b0 || sb.size() != 0) begin
      n_fail++; $display("FAIL stop_flush: cp=%b left=%0d, expected 0/0", bus.confirm_pass, sb.size());
    end
  endtask

  task automatic test_saturate_and_reset();
    bus.audio_ready = 1'b0;
    send_key(K_START);
    for (int i = 0; i < 300; i++) strobe(16'h0100 + 16'(i), (i < 5), 16'h0100 + 16'(i));
    n_assert++;
    if (bus.drop_count !== 8'd255) begin n_fail++; $display("FAIL drop_saturate: got %0d, expected 255", bus.drop_count); end
    n_assert++;
    if (bus.confirm_pass !== 1'b1 || bus.pass_data_audio !== 16'h0100) begin
      n_fail++; $display("FAIL stall_hold: cp=%b data=%h, expected 1/0100", bus.confirm_pass, bus.pass_data_audio);
    end
    send_key(K_MUTE);
    // Asynchronous reset in the middle of a stalled handshake.
    rstn = 1'b0;
    #2;
    n_assert++;
    if (bus.confirm_pass !== 1'b0 || bus.pass_data_audio !== '0 || bus.playing !== 1'b0 ||
        bus.muted !== 1'b0 || bus.drop_count !== 8'd0) begin
      n_fail++; $display("FAIL async_reset: cp=%b data=%h playing=%b muted=%b drops=%0d, expected all 0",
                         bus.confirm_pass, bus.pass_data_audio, bus.playing, bus.muted, bus.drop_count);
    end
    sb.delete();
    tick();
    rstn = 1'b1;
    bus.audio_ready = 1'b1;
    repeat (3) tick();
    n_assert++;
    if (bus.confirm_pass !== 1'b0) begin n_fail++; $display("FAIL post_reset_empty: cp=%b, expected 0", bus.confirm_pass); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stopped();
    test_backpressure();
    test_mute();
    test_stop_flush();
    test_saturate_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
